// File: rtl/pb_bar_pkg.sv
// Shared types and widths for the push-button bar-level block.
package pb_bar_pkg;

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} deb_state_t;

   localparam int LEVEL_W = 5;
   localparam int BAR_W   = 16;

   // One-hot bar word: bit (lvl-1) set for lvl in 1..16, all zero for lvl 0.
   function automatic logic [BAR_W-1:0] level_to_onehot(input logic [LEVEL_W-1:0] lvl);
      logic [BAR_W-1:0] oh;
      oh = '0;
      if (lvl != '0 && lvl <= LEVEL_W'(BAR_W)) begin
         oh = BAR_W'(1) << (lvl - LEVEL_W'(1));
      end
      return oh;
   endfunction

endpackage

// File: rtl/pb_debounce.sv
// One push-button channel: 2-flop synchronizer, stability counter and a
// four-state debouncer that emits a single-cycle press pulse when a press
// has been stable for DEBOUNCE_CYCLES samples. Releases emit nothing.
module pb_debounce
   import pb_bar_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic raw_i,
   output logic press_pulse_o
);

   localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES);

   logic       sync1_q, sync2_q;
   deb_state_t state_q, state_d;
   logic [3:0] count_q, count_d;
   logic       pulse_q, pulse_d;

   // Bring the raw asynchronous button into the clock domain.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   // Debouncer state, stability count and registered press pulse.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         count_q <= 4'd0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         pulse_q <= pulse_d;
      end
   end

   // Next-state logic; a count of 1 may already satisfy DEBOUNCE_CYCLES==1.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      pulse_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync2_q) begin
               count_d = 4'd1;
               if (DEB_LAST <= 4'd1) begin
                  state_d = HELD;
                  pulse_d = 1'b1;
               end else begin
                  state_d = PRESS_WAIT;
               end
            end
         end
         PRESS_WAIT: begin
            if (sync2_q) begin
               count_d = count_q + 4'd1;
               if (count_q + 4'd1 >= DEB_LAST) begin
                  state_d = HELD;
                  pulse_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         HELD: begin
            if (!sync2_q) begin
               count_d = 4'd1;
               state_d = (DEB_LAST <= 4'd1) ? IDLE : REL_WAIT;
            end
         end
         REL_WAIT: begin
            if (!sync2_q) begin
               count_d = count_q + 4'd1;
               if (count_q + 4'd1 >= DEB_LAST) begin
                  state_d = IDLE;
               end
            end else begin
               state_d = HELD;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = 4'd0;
         end
      endcase
   end

   assign press_pulse_o = pulse_q;

endmodule

// File: rtl/pb_bar_level.sv
// Saturating 0..MAX_LEVEL level driven by debounced up/down/clear buttons,
// published as a level word, a one-hot bar word, a decoder select and
// full/empty flags, all registered together on the same edge.
// Optional idle auto-decay is enabled by defining PB_BAR_AUTO_DECAY_EN.
module pb_bar_level
   import pb_bar_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 2,
   parameter int MAX_LEVEL       = 16,
   parameter int DECAY_TICKS     = 50
) (
   input  logic               hz100,
   input  logic               reset,
   input  logic               pb_up,
   input  logic               pb_dn,
   input  logic               pb_clr,
   output logic [LEVEL_W-1:0] level,
   output logic [BAR_W-1:0]   bar_onehot,
   output logic [2:0]         dec_sel,
   output logic               full,
   output logic               empty
);

   localparam logic [LEVEL_W-1:0] MAX_L = LEVEL_W'(MAX_LEVEL);

   logic               up_pulse, dn_pulse, clr_pulse;
   logic               decay_hit;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [BAR_W-1:0]   bar_q;
   logic               full_q, empty_q;

   pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
      .clk_i(hz100), .rst_n_i(reset), .raw_i(pb_up), .press_pulse_o(up_pulse)
   );
   pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
      .clk_i(hz100), .rst_n_i(reset), .raw_i(pb_dn), .press_pulse_o(dn_pulse)
   );
   pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
      .clk_i(hz100), .rst_n_i(reset), .raw_i(pb_clr), .press_pulse_o(clr_pulse)
   );

`ifdef PB_BAR_AUTO_DECAY_EN
   logic [15:0] idle_cnt_q, idle_cnt_d;
   logic        any_pulse;

   // Idle counter restarts on any press and whenever the level is empty.
   always_comb begin
      any_pulse  = up_pulse | dn_pulse | clr_pulse;
      decay_hit  = !any_pulse && (level_q != '0) &&
                   (idle_cnt_q == 16'(DECAY_TICKS - 1));
      idle_cnt_d = idle_cnt_q + 16'd1;
      if (any_pulse || level_q == '0 || decay_hit) begin
         idle_cnt_d = 16'd0;
      end
   end

   // Idle counter register.
   always_ff @(posedge hz100) begin
      if (!reset) idle_cnt_q <= 16'd0;
      else        idle_cnt_q <= idle_cnt_d;
   end
`else
   assign decay_hit = 1'b0;
`endif

   // Level update, clear first, then the up+down cancel, then single steps.
   always_comb begin
      level_d = level_q;
      if (clr_pulse) begin
         level_d = '0;
      end else if (up_pulse && dn_pulse) begin
         level_d = level_q;
      end else if (up_pulse) begin
         if (level_q < MAX_L) level_d = level_q + LEVEL_W'(1);
      end else if (dn_pulse) begin
         if (level_q != '0) level_d = level_q - LEVEL_W'(1);
      end else if (decay_hit) begin
         level_d = level_q - LEVEL_W'(1);
      end
   end

   // All outputs come from the next level so they move on the same edge.
   always_ff @(posedge hz100) begin
      if (!reset) begin
         level_q <= '0;
         bar_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         level_q <= level_d;
         bar_q   <= level_to_onehot(level_d);
         full_q  <= (level_d == MAX_L);
         empty_q <= (level_d == '0);
      end
   end

   assign level      = level_q;
   assign bar_onehot = bar_q;
   assign dec_sel    = level_q[2:0];
   assign full       = full_q;
   assign empty      = empty_q;

endmodule
